// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types, constants and byte-merge helper for sram_dp_be
package sram_pkg;

   localparam int RDW_READ_FIRST  = 0;
   localparam int RDW_WRITE_FIRST = 1;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } sram_state_t;

   function automatic logic [7:0] be_merge(
      input logic [7:0] old_byte,
      input logic [7:0] new_byte,
      input logic       be
   );
      return be ? new_byte : old_byte;
   endfunction

endpackage

// File: rtl/sram_clear_fsm.sv
// rtl/sram_clear_fsm.sv - post-reset clear sweep: state, clear counter, busy flag
// Emits one zero-write strobe per cycle over addresses 0..DEPTH-1, then parks in READY.
module sram_clear_fsm
   import sram_pkg::*;
#(
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   output logic              o_init_busy,
   output logic              o_clr_we,
   output logic [ADDR_W-1:0] o_clr_addr
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   sram_state_t       r_state;
   logic [ADDR_W-1:0] r_clr_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= CLEAR;
         r_clr_cnt <= '0;
      end else if (r_state == CLEAR) begin
         if (r_clr_cnt == LAST) begin
            r_state   <= READY;
            r_clr_cnt <= '0;
         end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
         end
      end
   end

   assign o_init_busy = (r_state == CLEAR);
   // The reset edge itself must not clear a word; the sweep starts on the first edge after release.
   assign o_clr_we    = (r_state == CLEAR) && !i_rst;
   assign o_clr_addr  = r_clr_cnt;

endmodule

// File: rtl/sram_dp_be.sv
// rtl/sram_dp_be.sv - simple-dual-port SRAM with byte enables, 1/2-cycle read, RDW policy
// Array, byte merge and read pipeline live here; the clear sweep is in sram_clear_fsm.
module sram_dp_be
   import sram_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 3,
   parameter int DEPTH    = 2**ADDR_W,
   parameter int RD_LAT   = 1,
   parameter int RDW_MODE = 0
) (
   input  logic                i_clk,
   input  logic                i_rst,
   output logic                o_init_busy,
   input  logic                i_we,
   input  logic [ADDR_W-1:0]   i_waddr,
   input  logic [DATA_W/8-1:0] i_wbe,
   input  logic [DATA_W-1:0]   i_din,
   input  logic                i_re,
   input  logic [ADDR_W-1:0]   i_raddr,
   output logic [DATA_W-1:0]   o_dout,
   output logic                o_dout_valid
);

   localparam int              NB      = DATA_W / 8;
   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_busy;
   logic              w_clr_we;
   logic [ADDR_W-1:0] w_clr_addr;
   logic              w_wr_in_range;
   logic              w_rd_in_range;
   logic              w_wr_en;
   logic              w_rd_en;
   logic [DATA_W-1:0] w_old;
   logic [DATA_W-1:0] w_merged;
   logic [DATA_W-1:0] w_rd_word;
   logic [DATA_W-1:0] r_d1;
   logic              r_v1;

   sram_clear_fsm #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_clear (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .o_init_busy (w_busy),
      .o_clr_we    (w_clr_we),
      .o_clr_addr  (w_clr_addr)
   );

   assign o_init_busy   = w_busy;
   assign w_wr_in_range = ({1'b0, i_waddr} < DEPTH_W);
   assign w_rd_in_range = ({1'b0, i_raddr} < DEPTH_W);
   assign w_wr_en       = i_we && !w_busy && !i_rst && w_wr_in_range;
   assign w_rd_en       = i_re && !w_busy && !i_rst;
   assign w_old         = w_wr_in_range ? r_mem[i_waddr] : '0;

   always_comb begin
      w_merged = '0;
      for (int i = 0; i < NB; i++) begin
         w_merged[8*i +: 8] = be_merge(w_old[8*i +: 8], i_din[8*i +: 8], i_wbe[i]);
      end
   end

   always_comb begin
      w_rd_word = w_rd_in_range ? r_mem[i_raddr] : '0;
      if (RDW_MODE == RDW_WRITE_FIRST && w_wr_en && i_raddr == i_waddr) begin
         w_rd_word = w_merged;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_clr_we) begin
         r_mem[w_clr_addr] <= '0;
      end else if (w_wr_en) begin
         r_mem[i_waddr] <= w_merged;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_d1 <= '0;
         r_v1 <= 1'b0;
      end else begin
         r_v1 <= w_rd_en;
         if (w_rd_en) begin
            r_d1 <= w_rd_word;
         end
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic [DATA_W-1:0] r_d2;
         logic              r_v2;

         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               r_d2 <= '0;
               r_v2 <= 1'b0;
            end else begin
               r_v2 <= r_v1;
               if (r_v1) begin
                  r_d2 <= r_d1;
               end
            end
         end

         assign o_dout       = r_d2;
         assign o_dout_valid = r_v2;
      end else begin : g_lat1
         assign o_dout       = r_d1;
         assign o_dout_valid = r_v1;
      end
   endgenerate

endmodule
